// File: rtl/cva6_lsu_issue_arbiter.sv
// cva6_lsu_issue_arbiter
//
// Purpose: merges a load requester and a store requester onto the single
// LSU issue port. It allows at most one outstanding load and one outstanding
// store, forces MIN_GAP idle cycles after every issue and honours lsu_ready_i.
// It retires requests on their memory responses. It also flags two errors,
// both sticky: a spurious response, and a response that is overdue.
//
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   ld_req_valid_i/addr_i/ready_o     load request handshake
//   st_req_valid_i/addr_i/ready_o     store request handshake
//   lsu_ready_i                       LSU can take a new instruction
//   lsu_instr_o/is_load_o/instr_valid_o  registered issue to the LSU
//   load_mem_resp_i, store_mem_resp_i response pulses
//   ld_busy_o, st_busy_o              request outstanding (FSM in WAIT)
//   ld_done_o, st_done_o              one-cycle retire pulses
//   spurious_o, timeout_o             sticky error flags
//
// Handshake: a request transfers on a rising edge where valid and ready are
// both high. ready is combinational, so a requester must not make valid
// depend on ready. At most one of the two readies is high in any cycle. The
// transferred request appears on the LSU port for exactly the next cycle.

module cva6_lsu_issue_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned MIN_GAP = 3,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ld_req_valid_i,
    input  logic [ADDR_W-1:0] ld_req_addr_i,
    output logic              ld_req_ready_o,
    input  logic              st_req_valid_i,
    input  logic [ADDR_W-1:0] st_req_addr_i,
    output logic              st_req_ready_o,
    input  logic              lsu_ready_i,
    output logic [ADDR_W-1:0] lsu_instr_o,
    output logic              lsu_is_load_o,
    output logic              lsu_instr_valid_o,
    input  logic              load_mem_resp_i,
    input  logic              store_mem_resp_i,
    output logic              ld_busy_o,
    output logic              st_busy_o,
    output logic              ld_done_o,
    output logic              st_done_o,
    output logic              spurious_o,
    output logic              timeout_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } req_state_e;

    localparam logic [7:0] GAP_LOAD = 8'(MIN_GAP);
    localparam logic [7:0] TMO_MAX  = 8'(TIMEOUT);

    req_state_e        ld_state_q, ld_state_d;
    req_state_e        st_state_q, st_state_d;
    logic [7:0]        gap_q, gap_d;
    logic              rr_st_q, rr_st_d;      // 1: store wins the next tie
    logic [ADDR_W-1:0] instr_q, instr_d;
    logic              is_load_q, is_load_d;
    logic              instr_valid_q, instr_valid_d;
    logic              ld_done_q, ld_done_d;
    logic              st_done_q, st_done_d;
    logic              spurious_q, spurious_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        ld_cnt_q, ld_cnt_d;
    logic [7:0]        st_cnt_q, st_cnt_d;

    logic ld_elig, st_elig, ld_grant, st_grant;

    // Eligibility is gated by rst_ni so that ready stays low while reset is held.
    always_comb begin
        ld_elig  = rst_ni & ld_req_valid_i & (ld_state_q == ST_IDLE)
                 & (gap_q == 8'd0) & lsu_ready_i;
        st_elig  = rst_ni & st_req_valid_i & (st_state_q == ST_IDLE)
                 & (gap_q == 8'd0) & lsu_ready_i;
        ld_grant = ld_elig & (~st_elig | ~rr_st_q);
        st_grant = st_elig & (~ld_elig | rr_st_q);
    end

    always_comb begin
        ld_state_d    = ld_state_q;
        st_state_d    = st_state_q;
        gap_d         = gap_q;
        rr_st_d       = rr_st_q;
        instr_d       = '0;
        is_load_d     = is_load_q;
        instr_valid_d = ld_grant | st_grant;
        ld_done_d     = 1'b0;
        st_done_d     = 1'b0;
        spurious_d    = spurious_q;
        ld_cnt_d      = ld_cnt_q;
        st_cnt_d      = st_cnt_q;

        if (ld_grant || st_grant) begin
            gap_d = GAP_LOAD;
        end else if (gap_q != 8'd0) begin
            gap_d = gap_q - 8'd1;
        end

        if (ld_grant) begin
            rr_st_d   = 1'b1;
            instr_d   = ld_req_addr_i;
            is_load_d = 1'b1;
        end else if (st_grant) begin
            rr_st_d   = 1'b0;
            instr_d   = st_req_addr_i;
            is_load_d = 1'b0;
        end

        // A response in IDLE is spurious even in the grant cycle, since the
        // request only becomes outstanding on the following edge.
        case (ld_state_q)
            ST_IDLE: begin
                if (ld_grant)        ld_state_d = ST_WAIT;
                if (load_mem_resp_i) spurious_d = 1'b1;
            end
            ST_WAIT: begin
                if (load_mem_resp_i) begin
                    ld_state_d = ST_IDLE;
                    ld_done_d  = 1'b1;
                end
            end
            default: ld_state_d = ST_IDLE;
        endcase

        case (st_state_q)
            ST_IDLE: begin
                if (st_grant)         st_state_d = ST_WAIT;
                if (store_mem_resp_i) spurious_d = 1'b1;
            end
            ST_WAIT: begin
                if (store_mem_resp_i) begin
                    st_state_d = ST_IDLE;
                    st_done_d  = 1'b1;
                end
            end
            default: st_state_d = ST_IDLE;
        endcase

        // Wait counters saturate at TIMEOUT so the flag cannot wrap away.
        if (ld_grant) begin
            ld_cnt_d = 8'd0;
        end else if (ld_state_q == ST_WAIT && ld_cnt_q != TMO_MAX) begin
            ld_cnt_d = ld_cnt_q + 8'd1;
        end
        if (st_grant) begin
            st_cnt_d = 8'd0;
        end else if (st_state_q == ST_WAIT && st_cnt_q != TMO_MAX) begin
            st_cnt_d = st_cnt_q + 8'd1;
        end

        timeout_d = timeout_q | (ld_cnt_d == TMO_MAX) | (st_cnt_d == TMO_MAX);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_state_q    <= ST_IDLE;
            st_state_q    <= ST_IDLE;
            gap_q         <= 8'd0;
            rr_st_q       <= 1'b0;
            instr_q       <= '0;
            is_load_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            ld_done_q     <= 1'b0;
            st_done_q     <= 1'b0;
            spurious_q    <= 1'b0;
            timeout_q     <= 1'b0;
            ld_cnt_q      <= 8'd0;
            st_cnt_q      <= 8'd0;
        end else begin
            ld_state_q    <= ld_state_d;
            st_state_q    <= st_state_d;
            gap_q         <= gap_d;
            rr_st_q       <= rr_st_d;
            instr_q       <= instr_d;
            is_load_q     <= is_load_d;
            instr_valid_q <= instr_valid_d;
            ld_done_q     <= ld_done_d;
            st_done_q     <= st_done_d;
            spurious_q    <= spurious_d;
            timeout_q     <= timeout_d;
            ld_cnt_q      <= ld_cnt_d;
            st_cnt_q      <= st_cnt_d;
        end
    end

    assign ld_req_ready_o    = ld_grant;
    assign st_req_ready_o    = st_grant;
    assign lsu_instr_o       = instr_q;
    assign lsu_is_load_o     = is_load_q;
    assign lsu_instr_valid_o = instr_valid_q;
    assign ld_busy_o         = (ld_state_q == ST_WAIT);
    assign st_busy_o         = (st_state_q == ST_WAIT);
    assign ld_done_o         = ld_done_q;
    assign st_done_o         = st_done_q;
    assign spurious_o        = spurious_q;
    assign timeout_o         = timeout_q;

endmodule

// File: tb/tb_cva6_lsu_issue_arbiter.sv
// Testbench for cva6_lsu_issue_arbiter: directed scenarios followed by a
// random phase. A behavioural model tracks the outstanding requests and the
// sticky flags, and an expected-issue queue holds the pending LSU issue.
module tb_cva6_lsu_issue_arbiter;
    localparam int ADDR_W  = 32;
    localparam int MIN_GAP = 3;
    localparam int TIMEOUT = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b1;
    logic              ld_req_valid_i = 1'b0;
    logic [ADDR_W-1:0] ld_req_addr_i = '0;
    logic              ld_req_ready_o;
    logic              st_req_valid_i = 1'b0;
    logic [ADDR_W-1:0] st_req_addr_i = '0;
    logic              st_req_ready_o;
    logic              lsu_ready_i = 1'b0;
    logic [ADDR_W-1:0] lsu_instr_o;
    logic              lsu_is_load_o;
    logic              lsu_instr_valid_o;
    logic              load_mem_resp_i = 1'b0;
    logic              store_mem_resp_i = 1'b0;
    logic              ld_busy_o, st_busy_o, ld_done_o, st_done_o;
    logic              spurious_o, timeout_o;

    cva6_lsu_issue_arbiter #(
        .ADDR_W(ADDR_W), .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ld_req_valid_i(ld_req_valid_i), .ld_req_addr_i(ld_req_addr_i),
        .ld_req_ready_o(ld_req_ready_o),
        .st_req_valid_i(st_req_valid_i), .st_req_addr_i(st_req_addr_i),
        .st_req_ready_o(st_req_ready_o),
        .lsu_ready_i(lsu_ready_i), .lsu_instr_o(lsu_instr_o),
        .lsu_is_load_o(lsu_is_load_o), .lsu_instr_valid_o(lsu_instr_valid_o),
        .load_mem_resp_i(load_mem_resp_i), .store_mem_resp_i(store_mem_resp_i),
        .ld_busy_o(ld_busy_o), .st_busy_o(st_busy_o),
        .ld_done_o(ld_done_o), .st_done_o(st_done_o),
        .spurious_o(spurious_o), .timeout_o(timeout_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit  m_ld_busy, m_st_busy, m_prefer_st, m_is_load;
    bit  m_ld_done, m_st_done, m_spur, m_tmo;
    int  m_gap, m_ld_wait, m_st_wait;
    logic [ADDR_W:0] exp_q[$];   // {is_load, addr} of the issue due next cycle

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ld_busy = 0; m_st_busy = 0; m_prefer_st = 0; m_is_load = 0;
        m_ld_done = 0; m_st_done = 0; m_spur = 0; m_tmo = 0;
        m_gap = 0; m_ld_wait = 0; m_st_wait = 0;
        exp_q.delete();
    endtask

    // Asserts reset while requests are valid, checks outputs immediately.
    task automatic apply_reset();
        ld_req_valid_i = 1; st_req_valid_i = 1; lsu_ready_i = 1;
        load_mem_resp_i = 0; store_mem_resp_i = 0;
        rst_ni = 0;
        #1;
        check("rst_ld_ready", 64'(ld_req_ready_o), 64'(0));
        check("rst_st_ready", 64'(st_req_ready_o), 64'(0));
        check("rst_instr_valid", 64'(lsu_instr_valid_o), 64'(0));
        check("rst_instr", 64'(lsu_instr_o), 64'(0));
        check("rst_is_load", 64'(lsu_is_load_o), 64'(0));
        check("rst_busy", 64'({ld_busy_o, st_busy_o}), 64'(0));
        check("rst_done", 64'({ld_done_o, st_done_o}), 64'(0));
        check("rst_flags", 64'({spurious_o, timeout_o}), 64'(0));
        @(posedge clk_i); #1;
        ld_req_valid_i = 0; st_req_valid_i = 0; lsu_ready_i = 0;
        rst_ni = 1;
        model_reset();
    endtask

    // Driver: one clock cycle. Called 1ns after a rising edge; returns 1ns
    // after the next one. Outputs are compared at the falling edge.
    task automatic step(input bit ldv, input logic [ADDR_W-1:0] lda,
                        input bit stv, input logic [ADDR_W-1:0] sta,
                        input bit rdy, input bit lr, input bit sr);
        bit e_ld, e_st, g_ld, g_st;
        logic [ADDR_W:0] item;
        ld_req_valid_i = ldv; ld_req_addr_i = lda;
        st_req_valid_i = stv; st_req_addr_i = sta;
        lsu_ready_i = rdy; load_mem_resp_i = lr; store_mem_resp_i = sr;
        @(negedge clk_i);
        e_ld = ldv && !m_ld_busy && m_gap == 0 && rdy;
        e_st = stv && !m_st_busy && m_gap == 0 && rdy;
        if (e_ld && e_st) begin
            g_ld = !m_prefer_st; g_st = m_prefer_st;
        end else begin
            g_ld = e_ld; g_st = e_st;
        end
        check("ld_ready", 64'(ld_req_ready_o), 64'(g_ld));
        check("st_ready", 64'(st_req_ready_o), 64'(g_st));
        check("ld_busy", 64'(ld_busy_o), 64'(m_ld_busy));
        check("st_busy", 64'(st_busy_o), 64'(m_st_busy));
        check("ld_done", 64'(ld_done_o), 64'(m_ld_done));
        check("st_done", 64'(st_done_o), 64'(m_st_done));
        check("spurious", 64'(spurious_o), 64'(m_spur));
        check("timeout", 64'(timeout_o), 64'(m_tmo));
        check("instr_valid", 64'(lsu_instr_valid_o), 64'(exp_q.size() != 0));
        check("is_load", 64'(lsu_is_load_o), 64'(m_is_load));
        if (exp_q.size() != 0) begin
            item = exp_q.pop_front();
            check("issue_addr", 64'(lsu_instr_o), 64'(item[ADDR_W-1:0]));
            check("issue_kind", 64'(lsu_is_load_o), 64'(item[ADDR_W]));
        end else begin
            check("idle_instr", 64'(lsu_instr_o), 64'(0));
        end

        // advance the model by one cycle
        if (m_ld_busy) begin
            if (m_ld_wait < TIMEOUT) m_ld_wait++;
            if (m_ld_wait == TIMEOUT) m_tmo = 1;
        end
        if (m_st_busy) begin
            if (m_st_wait < TIMEOUT) m_st_wait++;
            if (m_st_wait == TIMEOUT) m_tmo = 1;
        end
        if (g_ld) m_ld_wait = 0;
        if (g_st) m_st_wait = 0;
        m_ld_done = lr && m_ld_busy;
        m_st_done = sr && m_st_busy;
        if (lr && !m_ld_busy) m_spur = 1;
        if (sr && !m_st_busy) m_spur = 1;
        m_ld_busy = m_ld_busy ? !lr : g_ld;
        m_st_busy = m_st_busy ? !sr : g_st;
        if (g_ld || g_st) m_gap = MIN_GAP;
        else if (m_gap > 0) m_gap--;
        if (g_ld) begin
            m_prefer_st = 1; m_is_load = 1; exp_q.push_back({1'b1, lda});
        end else if (g_st) begin
            m_prefer_st = 0; m_is_load = 0; exp_q.push_back({1'b0, sta});
        end
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, '0, 0, '0, 1, 0, 0);
    endtask

    initial begin
        #2;
        apply_reset();

        // single load issue and retire
        step(1, 32'hcad, 0, '0, 1, 0, 0);
        check("t1_valid", 64'(lsu_instr_valid_o), 64'(1));
        check("t1_addr", 64'(lsu_instr_o), 64'(32'hcad));
        check("t1_is_load", 64'(lsu_is_load_o), 64'(1));
        check("t1_busy", 64'(ld_busy_o), 64'(1));
        idle(3);
        step(0, '0, 0, '0, 1, 1, 0);
        check("t1_done", 64'(ld_done_o), 64'(1));
        check("t1_busy_clr", 64'(ld_busy_o), 64'(0));

        // contention from reset: load first, store 4 cycles later
        apply_reset();
        step(1, 32'h100, 1, 32'h200, 1, 0, 0);
        check("t2_first_load", 64'(lsu_is_load_o), 64'(1));
        for (int k = 0; k < 3; k++) step(1, 32'h104, 1, 32'h200, 1, 0, 0);
        check("t2_no_early_st", 64'(st_busy_o), 64'(0));
        step(1, 32'h108, 1, 32'h200, 1, 0, 0);
        check("t2_store_issue", 64'({lsu_instr_valid_o, lsu_is_load_o}), 64'(2'b10));
        step(0, '0, 0, '0, 1, 1, 1);
        check("t2_both_done", 64'({ld_done_o, st_done_o}), 64'(2'b11));
        idle(3);
        step(1, 32'h300, 1, 32'h400, 1, 0, 0);
        check("t2_rr_load", 64'({lsu_instr_valid_o, lsu_is_load_o}), 64'(2'b11));

        // held load request while one is outstanding
        for (int k = 0; k < 4; k++) step(1, 32'h500, 0, '0, 1, 0, 0);
        step(1, 32'h500, 0, '0, 1, 1, 0);
        step(1, 32'h504, 0, '0, 1, 0, 0);
        check("t3_regrant", 64'({lsu_instr_valid_o, lsu_instr_o}), {31'd0, 1'b1, 32'h504});
        idle(2);
        step(0, '0, 0, '0, 1, 1, 0);
        idle(3);

        // lsu_ready_i low blocks grants
        for (int k = 0; k < 3; k++) step(1, 32'h600, 1, 32'h700, 0, 0, 0);
        check("t4_blocked", 64'(lsu_instr_valid_o), 64'(0));
        step(1, 32'h600, 1, 32'h700, 1, 0, 0);
        check("t4_grant", 64'(lsu_instr_valid_o), 64'(1));
        idle(2);
        step(0, '0, 0, '0, 1, 1, 1);

        // spurious store response
        apply_reset();
        step(0, '0, 0, '0, 1, 0, 1);
        check("t5_spurious", 64'(spurious_o), 64'(1));
        check("t5_no_done", 64'(st_done_o), 64'(0));
        idle(3);
        check("t5_sticky", 64'(spurious_o), 64'(1));

        // timeout, late retire, reset mid-WAIT
        apply_reset();
        step(1, 32'h800, 0, '0, 1, 0, 0);
        idle(7);
        check("t6_no_early_tmo", 64'(timeout_o), 64'(0));
        idle(1);
        check("t6_timeout", 64'(timeout_o), 64'(1));
        step(0, '0, 0, '0, 1, 1, 0);
        check("t6_late_done", 64'({ld_done_o, ld_busy_o}), 64'(2'b10));
        step(1, 32'h804, 0, '0, 1, 0, 0);
        idle(2);
        apply_reset();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if (i == 200) apply_reset();
            step($urandom_range(0, 2) != 0, $urandom,
                 $urandom_range(0, 2) != 0, $urandom,
                 $urandom_range(0, 4) != 0,
                 m_ld_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0),
                 m_st_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
